// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite memory slave: word-organised RAM with byte/half/word lanes,
// optional fixed wait states and a two-cycle ERROR response for illegal transfers.
module ahb_lite_slave_mem #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HTRANS,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  localparam int          IDX_W      = $clog2(MEM_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(MEM_WORDS) << 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ERR1 = 2'd2;
  localparam logic [1:0] ST_ERR2 = 2'd3;

  logic [1:0]       state;
  logic [3:0]       wait_cnt;
  logic             pending;
  logic [IDX_W+1:0] reg_addr;
  logic             reg_write;
  logic [1:0]       reg_size;

  logic [31:0]      mem [MEM_WORDS];

  logic             accept;
  logic             illegal;
  logic             data_done;
  logic [3:0]       byte_en;
  logic [IDX_W-1:0] word_idx;
  logic             unused_bits;

  assign unused_bits = ^{HBURST, HTRANS[0]};

  assign HREADYOUT = (state == ST_IDLE) || (state == ST_ERR2) ||
                     ((state == ST_WAIT) && (wait_cnt == 4'd0));
  assign HRESP     = (state == ST_ERR1) || (state == ST_ERR2);

  assign accept    = HSEL && HREADY && HTRANS[1] && HREADYOUT;
  assign data_done = pending && HREADYOUT;
  assign word_idx  = reg_addr[IDX_W+1:2];
  assign HRDATA    = (data_done && !reg_write) ? mem[word_idx] : 32'h0;

  // The range check uses the full byte address so out-of-range never aliases.
  always_comb begin
    illegal = 1'b0;
    if (HSIZE > 3'd2)
      illegal = 1'b1;
    if ((HSIZE == 3'd1) && HADDR[0])
      illegal = 1'b1;
    if ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00))
      illegal = 1'b1;
    if ({1'b0, HADDR} >= BYTE_LIMIT)
      illegal = 1'b1;
  end

  always_comb begin
    byte_en = 4'b0000;
    case (reg_size)
      2'd0:    byte_en = 4'b0001 << reg_addr[1:0];
      2'd1:    byte_en = reg_addr[1] ? 4'b1100 : 4'b0011;
      default: byte_en = 4'b1111;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wait_cnt  <= 4'd0;
      pending   <= 1'b0;
      reg_addr  <= '0;
      reg_write <= 1'b0;
      reg_size  <= 2'd0;
    end else begin
      if (data_done)
        pending <= 1'b0;
      case (state)
        ST_WAIT: begin
          if (wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
          else
            state <= ST_IDLE;
        end
        ST_ERR1: state <= ST_ERR2;
        ST_ERR2: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
      // A new address phase overrides whatever the completing phase left behind.
      if (accept) begin
        reg_addr  <= HADDR[IDX_W+1:0];
        reg_write <= HWRITE;
        reg_size  <= HSIZE[1:0];
        if (illegal) begin
          state   <= ST_ERR1;
          pending <= 1'b0;
        end else if (WAIT_STATES == 0) begin
          state   <= ST_IDLE;
          pending <= 1'b1;
        end else begin
          state    <= ST_WAIT;
          wait_cnt <= 4'(WAIT_STATES);
          pending  <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (!HRESET && data_done && reg_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b])
          mem[word_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_lite_slave_mem.md
AHB_LITE_SLAVE_MEM -- requirements
Module: ahb_lite_slave_mem

Interface
REQ-001: Parameter MEM_WORDS, 256, memory depth in 32-bit words (power of two; byte space = 4*MEM_WORDS).
REQ-002: Parameter WAIT_STATES, 0, number of HREADYOUT-low cycles inserted in every OKAY data phase (0..15).
REQ-003: One clock; reset is synchronous and active-high.
REQ-004: HCLK  in  1  bus clock; all state updates on its rising edge.
REQ-005: HRESET  in  1  synchronous active-high reset.
REQ-006: HSEL  in  1  slave select from decoder.
REQ-007: HADDR  in  32  byte address, address phase.
REQ-008: HWRITE  in  1  1=write, 0=read, address phase.
REQ-009: HSIZE  in  3  transfer size, 0=byte, 1=half, 2=word.
REQ-010: HBURST  in  3  burst type; accepted, not used for decode.
REQ-011: HTRANS  in  2  0=IDLE, 1=BUSY, 2=NONSEQ, 3=SEQ.
REQ-012: HWDATA  in  32  write data, data phase.
REQ-013: HREADY  in  1  bus-wide ready (previous transfer complete).
REQ-014: HRDATA  out  32  read data, data phase.
REQ-015: HREADYOUT  out  1  this slave's data-phase ready.
REQ-016: HRESP  out  1  0=OKAY, 1=ERROR.

Function
REQ-017: Address phase sampled only on a rising edge with HSEL=1, HREADY=1, HTRANS in {NONSEQ,SEQ}; HADDR, HWRITE, HSIZE registered.
REQ-018: HSEL=0, IDLE or BUSY at a sampled edge: no transfer; next cycle HREADYOUT=1, HRESP=0.
REQ-019: States: IDLE, WAIT, ERR1, ERR2; OKAY data phase runs in IDLE (WAIT_STATES=0) or WAIT.
REQ-020: Transfer is illegal if HSIZE>2, half with HADDR[0]=1, word with HADDR[1:0]!=0, or HADDR >= 4*MEM_WORDS.
REQ-021: Legal transfer, WAIT_STATES=0: data phase completes in the next cycle with HREADYOUT=1, HRESP=0.
REQ-022: Legal transfer, WAIT_STATES=N>0: enter WAIT, down-counter loaded with N; HREADYOUT=0 for N cycles, then 1 for one cycle with HRESP=0.
REQ-023: Illegal transfer: ERR1 (HRESP=1, HREADYOUT=0) one cycle, then ERR2 (HRESP=1, HREADYOUT=1) one cycle, then IDLE; no wait states; memory never modified.
REQ-024: Write: memory updated at edge ending the HREADYOUT=1 data cycle with HWDATA, little-endian lanes selected by registered HSIZE and HADDR[1:0]; unselected bytes unchanged.
REQ-025: Read: HRDATA = full 32-bit word at registered HADDR[.:2] during the completing data cycle (all lanes driven); HRDATA=0 in all other cycles.
REQ-026: Pipelining: a new address phase sampled on the same edge a data phase completes; zero-wait back-to-back transfers sustain one per cycle.
REQ-027: Write then read of the same address back-to-back returns the newly written data.
REQ-028: No address sampled while HREADYOUT=0 (HREADY=0 on shared bus); a master IDLE during ERR1 is ignored for the current response.
REQ-029: Memory index wraps modulo MEM_WORDS only after the range check; out-of-range never aliases.

Reset
REQ-030: HRESET=1 at an edge: state IDLE, wait counter 0, registered address-phase cleared, HREADYOUT=1, HRESP=0, HRDATA=0.
REQ-031: Reset mid-data-phase (WAIT/ERR1/ERR2) abandons the transfer; pending write not committed.
REQ-032: Memory contents not affected by reset.

Verification
REQ-033: HRESET=1 two cycles, then 0 -> HREADYOUT=1, HRESP=0, HRDATA=0x00000000 on first post-reset cycle.
REQ-034: WAIT_STATES=0, word NONSEQ write 0x10 = 0xDEADBEEF, then read 0x10 -> HRDATA=0xDEADBEEF, HREADYOUT=1 each data cycle.
REQ-035: After REQ-034, byte write 0xAA to 0x13 (HWDATA=0xAA000000) -> read 0x10 returns 0xAAADBEEF.
REQ-036: Word write 0x02 = 0x12345678 -> HRESP=1/HREADYOUT=0 then HRESP=1/HREADYOUT=1; read 0x00 returns prior value unchanged; read 0x400 (MEM_WORDS=256) -> same ERROR pattern.
REQ-037: WAIT_STATES=2, read 0x10 -> HREADYOUT=0 two cycles, then 1 with HRDATA=0xAAADBEEF.
REQ-038: Pipelined NONSEQ write 0x20=0xCAFEF00D immediately followed by NONSEQ read 0x20 -> read data phase returns 0xCAFEF00D; IDLE/BUSY cycles interleaved return OKAY zero-wait.
